// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with baud timing, TX/RX framers and TX/RX FIFOs.
// Ports: clk, rst (sync, active high); rs232_rx/rs232_tx serial pins;
//        tx_data/tx_valid/tx_ready host->line stream; rx_data/rx_valid/rx_ready line->host
//        stream (first-word fall-through); tx_busy; parity_err/frame_err/overrun_err pulses.

// Synchronous FIFO with first-word fall-through read and extra-MSB pointers.
module uart_fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    // A write into a full FIFO is still taken when the head leaves in the same cycle.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage, no reset needed
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

module uart_fifo_core #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rs232_rx,
    output logic                 rs232_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 tx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    localparam int unsigned DIV     = CLK_HZ / BAUD;
    localparam int unsigned CW      = $clog2(DIV);
    localparam int unsigned BW      = 4;
    localparam logic        PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_state_nxt;
    logic [CW-1:0]        tx_cnt, tx_cnt_nxt;
    logic [BW-1:0]        tx_bit, tx_bit_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic                 tx_par, tx_par_nxt;
    logic                 tx_line_nxt;
    logic                 tx_pop;
    logic                 tx_end;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_full, tx_empty;

    uart_fifo_sync #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .wr_en(tx_valid), .wr_data(tx_data),
        .rd_en(tx_pop), .rd_data(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    assign tx_ready = !tx_full;
    assign tx_end   = (tx_cnt == CW'(DIV - 1));

    // TX next state; line value is registered so it trails the state by one cycle
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_line_nxt  = 1'b1;
        tx_pop       = 1'b0;
        if (tx_state != TX_IDLE) tx_cnt_nxt = tx_end ? '0 : tx_cnt + CW'(1);
        case (tx_state)
            TX_IDLE:  tx_pop = !tx_empty;
            TX_START: begin
                tx_line_nxt = 1'b0;
                if (tx_end) begin
                    tx_state_nxt = TX_DATA;
                    tx_bit_nxt   = '0;
                end
            end
            TX_DATA: begin
                tx_line_nxt = tx_shift[0];
                if (tx_end) begin
                    tx_shift_nxt = tx_shift >> 1;
                    if (tx_bit == BW'(DATA_BITS - 1)) begin
                        tx_state_nxt = (PARITY != 0) ? TX_PAR : TX_STOP;
                        tx_bit_nxt   = '0;
                    end else begin
                        tx_bit_nxt = tx_bit + BW'(1);
                    end
                end
            end
            TX_PAR: begin
                tx_line_nxt = tx_par;
                if (tx_end) begin
                    tx_state_nxt = TX_STOP;
                    tx_bit_nxt   = '0;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    if (tx_bit == BW'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when data is waiting
                        tx_state_nxt = TX_IDLE;
                        tx_pop       = !tx_empty;
                    end else begin
                        tx_bit_nxt = tx_bit + BW'(1);
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        if (tx_pop) begin
            tx_shift_nxt = tx_head;
            tx_par_nxt   = (^tx_head) ^ PAR_ODD;
            tx_cnt_nxt   = '0;
            tx_state_nxt = TX_START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            rs232_tx <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
            rs232_tx <= tx_line_nxt;
            tx_busy  <= (tx_state != TX_IDLE) || !tx_empty;
        end
    end

    // ---------------- RX ----------------
    rx_state_t            rx_state, rx_state_nxt;
    logic [CW-1:0]        rx_cnt, rx_cnt_nxt;
    logic [BW-1:0]        rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
    logic                 rx_par_bit, rx_par_bit_nxt;
    logic                 rx_s1, rx_s2, rx_s3;
    logic                 rx_mid;
    logic                 rx_push, rx_push_nxt;
    logic                 frame_err_nxt, parity_err_nxt;
    logic                 rx_full, rx_empty;

    uart_fifo_sync #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .wr_en(rx_push), .wr_data(rx_shift),
        .rd_en(rx_ready), .rd_data(rx_data),
        .full(rx_full), .empty(rx_empty)
    );

    assign rx_valid = !rx_empty;
    assign rx_mid   = (rx_cnt == CW'(DIV - 1));

    // RX next state; rx_s3 holds the previous synchronised sample for edge detection
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt;
        rx_bit_nxt     = rx_bit;
        rx_shift_nxt   = rx_shift;
        rx_par_bit_nxt = rx_par_bit;
        rx_push_nxt    = 1'b0;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
        if (rx_state != RX_IDLE) rx_cnt_nxt = rx_mid ? '0 : rx_cnt + CW'(1);
        case (rx_state)
            RX_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a high line means the falling edge was a glitch
                if (rx_cnt == CW'(DIV / 2 - 1)) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_shift_nxt = {rx_s2, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == BW'(DATA_BITS - 1)) begin
                        rx_state_nxt = (PARITY != 0) ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + BW'(1);
                    end
                end
            end
            RX_PAR: begin
                if (rx_mid) begin
                    rx_par_bit_nxt = rx_s2;
                    rx_state_nxt   = RX_STOP;
                end
            end
            RX_STOP: begin
                // Only the first stop bit is checked; return to IDLE mid-bit to resync early
                if (rx_mid) begin
                    rx_state_nxt = RX_IDLE;
                    if (!rx_s2) begin
                        frame_err_nxt = 1'b1;
                    end else if ((PARITY != 0) && (rx_par_bit != ((^rx_shift) ^ PAR_ODD))) begin
                        parity_err_nxt = 1'b1;
                    end else begin
                        rx_push_nxt = 1'b1;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_par_bit  <= 1'b0;
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_s3       <= 1'b1;
            rx_push     <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_state    <= rx_state_nxt;
            rx_cnt      <= rx_cnt_nxt;
            rx_bit      <= rx_bit_nxt;
            rx_shift    <= rx_shift_nxt;
            rx_par_bit  <= rx_par_bit_nxt;
            rx_s1       <= rs232_rx;
            rx_s2       <= rx_s1;
            rx_s3       <= rx_s2;
            rx_push     <= rx_push_nxt;
            frame_err   <= frame_err_nxt;
            parity_err  <= parity_err_nxt;
            // A same-cycle pop frees the slot, so only a stalled full FIFO overruns
            overrun_err <= rx_push && rx_full && !rx_ready;
        end
    end
endmodule
